// File: rtl/mem_access_pkg.sv
// Shared encodings and byte-lane helpers for the MEM-stage load/store engine.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_LSIGN = 2'b10;
    localparam logic [1:0] EXT_LZERO = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    // Size 2'b11 is reserved and behaves exactly like a word everywhere.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_enable = 4'b0001 << lane;
            SZ_HALF: byte_enable = 4'b0011 << lane;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: replicate_wdata = {4{wdata[7:0]}};
            SZ_HALF: replicate_wdata = {2{wdata[15:0]}};
            default: replicate_wdata = wdata;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            default: is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: force_align = lane;
            SZ_HALF: force_align = {lane[1], 1'b0};
            default: force_align = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the load/store engine (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load extractor: picks the byte/half at the lane and sign- or zero-extends it.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_ext,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;
    logic        w_zero_ext;

    assign w_shifted  = i_rdata >> {i_lane, 3'b000};
    assign w_zero_ext = (i_ext == EXT_ZERO) || (i_ext == EXT_LZERO);

    always_comb begin
        // NOTE: default assignment first so no path leaves o_rdata unassigned (no latch).
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: o_rdata = w_zero_ext ? {24'h0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: o_rdata = w_zero_ext ? {16'h0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack to data memory, byte lanes, load extension, stall.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic [1:0]            ext_type_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  misalign_o,
    mem_access_unit_if.master     mem
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic [1:0]        r_ext;
    logic [1:0]        r_lane;
    logic [7:0]        r_tmo;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    logic              w_reject;
    logic              w_accept;
    logic [1:0]        w_lane;
    logic [31:0]       w_load_data;

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_reject   = is_misaligned(size_i, addr_i[1:0]);
    assign w_lane     = addr_i[1:0];
    assign misalign_o = r_misalign;
`else
    assign w_reject   = 1'b0;
    assign w_lane     = force_align(size_i, addr_i[1:0]);
    assign misalign_o = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && req_i && !w_reject;
    assign stall_o  = w_accept || (r_state == BUSY);

    load_align u_load_align (
        .i_rdata (mem.mem_rdata_i),
        .i_lane  (r_lane),
        .i_size  (r_size),
        .i_ext   (r_ext),
        .o_rdata (w_load_data)
    );

    // mem_req_o clears with the async reset, abandoning any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_ext       <= EXT_SIGN;
            r_lane      <= 2'b00;
            r_tmo       <= 8'h00;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                    r_misalign <= 1'b0;
                    if (req_i && w_reject) begin
                        r_state    <= RESP;
                        r_done     <= 1'b1;
                        r_misalign <= 1'b1;
                        r_rdata    <= 32'h0;
                    end
`endif
                    if (w_accept) begin
                        r_state     <= BUSY;
                        r_we        <= we_i;
                        r_size      <= size_i;
                        r_ext       <= ext_type_i;
                        r_lane      <= w_lane;
                        r_tmo       <= 8'h00;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
                        r_mem_be    <= byte_enable(size_i, w_lane);
                        r_mem_wdata <= replicate_wdata(size_i, wdata_i);
                    end
                end
                BUSY: begin
                    if (mem.mem_ack_i) begin
                        r_state   <= RESP;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        r_rdata   <= r_we ? 32'h0 : w_load_data;
                        r_mem_req <= 1'b0;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state   <= RESP;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_rdata   <= 32'h0;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                    r_misalign <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign done_o          = r_done;
    assign err_o           = r_err;
    assign rdata_o         = r_rdata;
    assign mem.mem_req_o   = r_mem_req;
    assign mem.mem_we_o    = r_we;
    assign mem.mem_addr_o  = r_mem_addr;
    assign mem.mem_be_o    = r_mem_be;
    assign mem.mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4); honours MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic [1:0]  ext_type_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    mem_access_unit_if #(.ADDR_W(32)) mem_bus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .ext_type_i (ext_type_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .misalign_o (misalign_o),
        .mem        (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic [1:0] ext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_i      = 1'b1;
        we_i       = we;
        size_i     = size;
        ext_type_i = ext;
        addr_i     = addr;
        wdata_i    = wdata;
    endtask

    // Single load with ack in the first BUSY cycle; done_o expected two cycles after acceptance.
    task automatic run_load(input string tag, input logic [1:0] size, input logic [1:0] ext,
                            input logic [31:0] addr, input logic [31:0] word,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
        drive(1'b0, size, ext, addr, 32'h0);
        #1;
        check({tag, "_stall_c0"}, stall_o, 1'b1);
        tick();
        req_i = 1'b0;
        check({tag, "_req_c1"}, mem_bus.mem_req_o, 1'b1);
        check({tag, "_addr"}, mem_bus.mem_addr_o, exp_addr);
        check({tag, "_be"}, mem_bus.mem_be_o, exp_be);
        check({tag, "_done_c1"}, done_o, 1'b0);
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = word;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        check({tag, "_done_c2"}, done_o, 1'b1);
        check({tag, "_rdata"}, rdata_o, exp_data);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_stall_resp"}, stall_o, 1'b0);
        tick();
        check({tag, "_done_c3"}, done_o, 1'b0);
    endtask

    initial begin
        rst_n               = 1'b0;
        req_i               = 1'b0;
        we_i                = 1'b0;
        size_i              = 2'b00;
        ext_type_i          = 2'b00;
        addr_i              = 32'h0;
        wdata_i             = 32'h0;
        mem_bus.mem_ack_i   = 1'b0;
        mem_bus.mem_rdata_i = 32'h0;

        #12;
        check("rst_stall", stall_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err", err_o, 1'b0);
        check("rst_misalign", misalign_o, 1'b0);
        check("rst_mem_req", mem_bus.mem_req_o, 1'b0);
        check("rst_mem_be", mem_bus.mem_be_o, 4'h0);
        check("rst_mem_addr", mem_bus.mem_addr_o, 32'h0);
        rst_n = 1'b1;
        tick();

        // LB, lane 3, sign extension of 0x80.
        run_load("lb", 2'b00, 2'b10, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);

        // Stray ack while idle must not produce a completion.
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'hDEAD_0000;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        check("idle_ack_done", done_o, 1'b0);
        check("idle_ack_req", mem_bus.mem_req_o, 1'b0);

        run_load("lhu", 2'b01, 2'b11, 32'h0000_2002, 32'h9ABC_5678, 32'h0000_2000, 4'b1100, 32'h0000_9ABC);
        run_load("lh",  2'b01, 2'b00, 32'h0000_2002, 32'h9ABC_5678, 32'h0000_2000, 4'b1100, 32'hFFFF_9ABC);
        run_load("lbu", 2'b00, 2'b01, 32'h0000_2001, 32'h9ABC_5678, 32'h0000_2000, 4'b0010, 32'h0000_0056);

        // SB with the ack delayed to the third BUSY cycle.
        drive(1'b1, 2'b00, 2'b00, 32'h0000_3001, 32'h0000_00AA);
        #1;
        check("sb_stall_c0", stall_o, 1'b1);
        tick();
        req_i = 1'b0;
        check("sb_req", mem_bus.mem_req_o, 1'b1);
        check("sb_we", mem_bus.mem_we_o, 1'b1);
        check("sb_be", mem_bus.mem_be_o, 4'b0010);
        check("sb_wdata", mem_bus.mem_wdata_o, 32'hAAAA_AAAA);
        check("sb_addr", mem_bus.mem_addr_o, 32'h0000_3000);
        check("sb_stall_b1", stall_o, 1'b1);
        tick();
        check("sb_stall_b2", stall_o, 1'b1);
        check("sb_be_stable", mem_bus.mem_be_o, 4'b0010);
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        check("sb_done", done_o, 1'b1);
        check("sb_rdata", rdata_o, 32'h0);
        check("sb_stall_resp", stall_o, 1'b0);
        tick();

        // SH at lane 2: lanes 3:2 enabled, halfword replicated.
        drive(1'b1, 2'b01, 2'b00, 32'h0000_3102, 32'hFFFF_BEEF);
        tick();
        req_i = 1'b0;
        check("sh_be", mem_bus.mem_be_o, 4'b1100);
        check("sh_wdata", mem_bus.mem_wdata_o, 32'hBEEF_BEEF);
        mem_bus.mem_ack_i = 1'b1;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        check("sh_done", done_o, 1'b1);
        tick();

        // Timeout: no ack for 4 BUSY cycles.
        drive(1'b0, 2'b10, 2'b00, 32'h0000_5000, 32'h0);
        tick();
        req_i = 1'b0;
        tick();
        tick();
        tick();
        check("tmo_req_b4", mem_bus.mem_req_o, 1'b1);
        check("tmo_done_b4", done_o, 1'b0);
        tick();
        check("tmo_done", done_o, 1'b1);
        check("tmo_err", err_o, 1'b1);
        check("tmo_req_off", mem_bus.mem_req_o, 1'b0);
        check("tmo_stall", stall_o, 1'b0);
        tick();
        check("tmo_done_clr", done_o, 1'b0);
        check("tmo_err_clr", err_o, 1'b0);

        // Ack coinciding with the timeout cycle wins.
        drive(1'b0, 2'b10, 2'b00, 32'h0000_5000, 32'h0);
        tick();
        req_i = 1'b0;
        tick();
        tick();
        tick();
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'h1234_5678;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        check("ack4_done", done_o, 1'b1);
        check("ack4_err", err_o, 1'b0);
        check("ack4_rdata", rdata_o, 32'h1234_5678);
        tick();

        // Request held through RESP is accepted only in the following IDLE cycle; size 11 acts as word.
        drive(1'b0, 2'b11, 2'b00, 32'h0000_7000, 32'h0);
        tick();
        check("b2b_be", mem_bus.mem_be_o, 4'b1111);
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'h0000_00F0;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        check("b2b_done1", done_o, 1'b1);
        check("b2b_rdata1", rdata_o, 32'h0000_00F0);
        check("b2b_stall_resp", stall_o, 1'b0);
        tick();
        check("b2b_idle_done", done_o, 1'b0);
        check("b2b_idle_req", mem_bus.mem_req_o, 1'b0);
        check("b2b_idle_stall", stall_o, 1'b1);
        tick();
        req_i = 1'b0;
        check("b2b_busy2", mem_bus.mem_req_o, 1'b1);
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'h0000_0055;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        check("b2b_done2", done_o, 1'b1);
        check("b2b_rdata2", rdata_o, 32'h0000_0055);
        tick();

        // Asynchronous reset while BUSY.
        drive(1'b0, 2'b10, 2'b00, 32'h0000_6000, 32'h0);
        tick();
        req_i = 1'b0;
        check("rstmid_req_before", mem_bus.mem_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmid_req_drop", mem_bus.mem_req_o, 1'b0);
        check("rstmid_done", done_o, 1'b0);
        check("rstmid_stall", stall_o, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rstmid_done_after", done_o, 1'b0);
        check("rstmid_req_after", mem_bus.mem_req_o, 1'b0);
        run_load("lw_post_rst", 2'b10, 2'b01, 32'h0000_6004, 32'hCAFE_BABE, 32'h0000_6004, 4'b1111, 32'hCAFE_BABE);

`ifdef MEM_MISALIGN_TRAP_EN
        drive(1'b0, 2'b10, 2'b00, 32'h0000_4002, 32'h0);
        #1;
        check("mis_lw_stall_c0", stall_o, 1'b0);
        tick();
        req_i = 1'b0;
        check("mis_lw_req", mem_bus.mem_req_o, 1'b0);
        check("mis_lw_done", done_o, 1'b1);
        check("mis_lw_flag", misalign_o, 1'b1);
        check("mis_lw_rdata", rdata_o, 32'h0);
        tick();
        check("mis_lw_done_clr", done_o, 1'b0);
        check("mis_lw_flag_clr", misalign_o, 1'b0);
        drive(1'b0, 2'b01, 2'b01, 32'h0000_4003, 32'h0);
        #1;
        check("mis_lh_stall_c0", stall_o, 1'b0);
        tick();
        req_i = 1'b0;
        check("mis_lh_req", mem_bus.mem_req_o, 1'b0);
        check("mis_lh_flag", misalign_o, 1'b1);
        tick();
`else
        run_load("lw_unaligned", 2'b10, 2'b00, 32'h0000_4002, 32'hDEAD_BEEF, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF);
        check("lw_unaligned_flag", misalign_o, 1'b0);
        run_load("lhu_unaligned", 2'b01, 2'b01, 32'h0000_4003, 32'h1122_3344, 32'h0000_4000, 4'b1100, 32'h0000_1122);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine of the 5-stage MIPS pipeline.
- Consumes the effective address (base + sign-extended immediate) and the load-extension type that the immediate extension stage encodes.
- Runs a req/ack handshake to data memory, generates byte enables, and returns aligned, sign- or zero-extended load data.
- Stalls the pipeline while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without ack before a bus error is declared; range 1..255.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req_i  in  1  MEM-stage memory op valid
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word
- ext_type_i  in  2  load extension: 00/10 sign, 01/11 zero
- addr_i  in  ADDR_W  effective byte address
- wdata_i  in  32  store data, right-justified
- stall_o  out  1  freeze upstream stages
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load data, valid while done_o = 1
- err_o  out  1  bus timeout, valid with done_o
- misalign_o  out  1  misaligned request flagged (see Optional Feature)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  word address, low 2 bits = 0
- mem_be_o  out  4  byte enables, bit n = byte lane n
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  memory accept/complete
- mem_rdata_i  in  32  read word, valid with mem_ack_i

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on rst_n = 0.
- Reset values: state IDLE. All outputs 0, except stall_o, which follows its combinational equation.
- States and transitions:
  - IDLE: on req_i (and not rejected), latch we/size/ext/addr/wdata, go to BUSY.
  - BUSY: mem_req_o = 1, all mem_* outputs stable. On mem_ack_i, capture mem_rdata_i and go to RESP. When the timeout counter reaches TIMEOUT_CYCLES without ack, go to RESP with err_o = 1.
  - RESP: done_o = 1 for exactly one cycle, then go to IDLE.
- Stall: stall_o = (IDLE and req_i and not rejected) or BUSY. stall_o is 0 in RESP so the pipeline advances.
- Latency: request accepted at cycle 0, mem_req_o rises at cycle 1. With ack at cycle k, done_o is high at cycle k+1. Minimum is 2 cycles.
- Back-to-back requests: a request present in RESP is not accepted there. It is accepted in the following IDLE cycle.
- Byte lanes are little-endian, using lane = addr[1:0].
  - Byte: be = 0001 << lane; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 << lane; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111; wdata unchanged.
- Load extract: select the byte or half at the lane, then sign-extend (ext 00/10) or zero-extend (ext 01/11). Words pass through and ignore ext.
- Store completion: rdata_o = 0.
- Timeout counter: 8 bits, cleared on entry to BUSY. If mem_ack_i and timeout coincide, ack wins and err_o = 0.
- mem_ack_i outside BUSY is ignored.
- Reset mid-operation: mem_req_o drops asynchronously and no done_o is issued. Memory must tolerate an abandoned request.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0] = 1 is misaligned; a word access with addr[1:0] ≠ 0 is misaligned.
  - A misaligned request in IDLE is rejected: no memory request.
  - The next cycle gives done_o = 1, misalign_o = 1, rdata_o = 0; stall_o is 0 during the rejecting cycle.
- Undefined:
  - misalign_o is tied to 0.
  - Offending low address bits are forced to alignment: half uses addr[0] = 0, word uses addr[1:0] = 0.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - EXT_SIGN/EXT_ZERO/EXT_LSIGN/EXT_LZERO;
  - state enum IDLE/BUSY/RESP.
- One combinational sub-module, load_align, computes (rdata, lane, size, ext) -> rdata_o. It is reused by bench reference models.

Test Plan:
- LB, addr 0x1003, ext 10, memory word 0x80FF1234, ack at first BUSY cycle -> done_o at cycle 2, rdata_o = 0xFFFFFF80.
- LHU, addr 0x2002, ext 11, word 0x9ABC5678 -> rdata_o = 0x00009ABC; LH with ext 00 -> 0xFFFF9ABC.
- SB, addr 0x3001, wdata 0x000000AA -> mem_be_o = 0010, mem_wdata_o = 0xAAAAAAAA, mem_addr_o = 0x3000, stall_o high until RESP.
- No ack with TIMEOUT_CYCLES = 4 -> done_o and err_o after 4 BUSY cycles. Ack on the 4th cycle -> err_o = 0.
- rst_n pulled low while in BUSY -> mem_req_o = 0 immediately, no done_o, next request serviced normally.
- With MEM_MISALIGN_TRAP_EN, LW at 0x4002 -> no mem_req_o, done_o and misalign_o next cycle. Without the macro, the same request reads 0x4000.
